dmem_arbiter: RTL and testbench

Arbitrates the single-port data memory between the CPU pipeline (load/store requests issued by the execute stage) and an external requester (debug/DMA port). The CPU has priority. A starvation counter forces an external grant after a bounded wait. While the CPU is denied, the block stalls the pipeline. It sits between the execute stage's dmem address/data outputs and the data memory macro.

---
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arbiter_if                                                 |
// | Brief    : CPU / external requester / memory-macro signals of the arbiter  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16
);
  // CPU pipeline side
  logic                       in_cpu_rd_en;
  logic [DMEM_ADDR_WIDTH-1:0] in_cpu_rd_addr;
  logic                       in_cpu_wr_en;
  logic [DMEM_ADDR_WIDTH-1:0] in_cpu_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] in_cpu_wr_word;
  logic                       out_cpu_stall;

  // External (debug/DMA) side
  logic                       in_ext_req;
  logic                       in_ext_we;
  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr;
  logic [DMEM_WORD_WIDTH-1:0] in_ext_wdata;
  logic                       out_ext_gnt;
  logic                       out_ext_rvalid;
  logic [DMEM_WORD_WIDTH-1:0] out_ext_rdata;

  // Memory macro side
  logic                       out_mem_en;
  logic                       out_mem_we;
  logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr;
  logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word;
  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word;

  modport slave (
    input  in_cpu_rd_en, in_cpu_rd_addr, in_cpu_wr_en, in_cpu_wr_addr, in_cpu_wr_word,
    output out_cpu_stall,
    input  in_ext_req, in_ext_we, in_ext_addr, in_ext_wdata,
    output out_ext_gnt, out_ext_rvalid, out_ext_rdata,
    output out_mem_en, out_mem_we, out_mem_addr, out_mem_wr_word,
    input  in_mem_rd_word
  );

  modport master (
    output in_cpu_rd_en, in_cpu_rd_addr, in_cpu_wr_en, in_cpu_wr_addr, in_cpu_wr_word,
    input  out_cpu_stall,
    output in_ext_req, in_ext_we, in_ext_addr, in_ext_wdata,
    input  out_ext_gnt, out_ext_rvalid, out_ext_rdata,
    input  out_mem_en, out_mem_we, out_mem_addr, out_mem_wr_word,
    output in_mem_rd_word
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                    |
// | Brief    : Single-port dmem arbiter, CPU priority with starvation-bounded  |
// |            external access and deferred CPU read behind a CPU write        |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int STARVE_LIMIT    = 4,
  parameter int CNT_WIDTH       = 3
) (
  input wire            clock,
  input wire            reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] c_starve_limit = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one      = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_EXT    = 2'd1,
    SEL_CPU_WR = 2'd2,
    SEL_CPU_RD = 2'd3
  } sel_t;

  logic [CNT_WIDTH-1:0]       r_wait_cnt;
  logic                       r_cpu_rd_pend;
  logic                       r_ext_rd_issued;
  logic [DMEM_WORD_WIDTH-1:0] r_ext_rdata;

  logic                       w_force_ext;
  logic                       w_cpu_wr;
  logic                       w_cpu_rd;
  logic                       w_cpu_any;
  sel_t                       w_sel;

  logic                       w_mem_en;
  logic                       w_mem_we;
  logic [DMEM_ADDR_WIDTH-1:0] w_mem_addr;
  logic [DMEM_WORD_WIDTH-1:0] w_mem_wr_word;
  logic                       w_ext_gnt;
  logic                       w_cpu_stall;

  // The write half of a write+read pair is already done once the read is pending.
  assign w_force_ext = (r_wait_cnt == c_starve_limit);
  assign w_cpu_wr    = bus.in_cpu_wr_en & ~r_cpu_rd_pend;
  assign w_cpu_rd    = bus.in_cpu_rd_en;
  assign w_cpu_any   = w_cpu_wr | w_cpu_rd;

  always_comb begin
    w_sel = SEL_NONE;
    if (w_force_ext && bus.in_ext_req) begin
      w_sel = SEL_EXT;
    end else if (w_cpu_wr) begin
      w_sel = SEL_CPU_WR;
    end else if (w_cpu_rd) begin
      w_sel = SEL_CPU_RD;
    end else if (bus.in_ext_req) begin
      w_sel = SEL_EXT;
    end
  end

  // All combinational outputs are forced low while reset is held.
  always_comb begin
    w_mem_en      = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = '0;
    w_mem_wr_word = '0;
    w_ext_gnt     = 1'b0;
    w_cpu_stall   = 1'b0;
    if (!reset) begin
      case (w_sel)
        SEL_EXT: begin
          w_mem_en      = 1'b1;
          w_mem_we      = bus.in_ext_we;
          w_mem_addr    = bus.in_ext_addr;
          w_mem_wr_word = bus.in_ext_we ? bus.in_ext_wdata : '0;
          w_ext_gnt     = 1'b1;
          w_cpu_stall   = w_cpu_any;
        end
        SEL_CPU_WR: begin
          w_mem_en      = 1'b1;
          w_mem_we      = 1'b1;
          w_mem_addr    = bus.in_cpu_wr_addr;
          w_mem_wr_word = bus.in_cpu_wr_word;
          w_cpu_stall   = bus.in_cpu_rd_en;
        end
        SEL_CPU_RD: begin
          w_mem_en      = 1'b1;
          w_mem_addr    = bus.in_cpu_rd_addr;
        end
        default: begin
          w_mem_en      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt      <= '0;
      r_cpu_rd_pend   <= 1'b0;
      r_ext_rd_issued <= 1'b0;
      r_ext_rdata     <= '0;
    end else begin
      if (!bus.in_ext_req || w_ext_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != c_starve_limit) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_one;
      end

      if (w_sel == SEL_CPU_WR) begin
        r_cpu_rd_pend <= bus.in_cpu_rd_en;
      end else if (w_sel == SEL_CPU_RD) begin
        r_cpu_rd_pend <= 1'b0;
      end

      r_ext_rd_issued <= w_ext_gnt & ~bus.in_ext_we;

      // Latch the returning word so it stays visible after rvalid drops.
      if (r_ext_rd_issued) begin
        r_ext_rdata <= bus.in_mem_rd_word;
      end
    end
  end

  assign bus.out_mem_en      = w_mem_en;
  assign bus.out_mem_we      = w_mem_we;
  assign bus.out_mem_addr    = w_mem_addr;
  assign bus.out_mem_wr_word = w_mem_wr_word;
  assign bus.out_ext_gnt     = w_ext_gnt;
  assign bus.out_cpu_stall   = w_cpu_stall;
  assign bus.out_ext_rvalid  = r_ext_rd_issued;
  assign bus.out_ext_rdata   = r_ext_rd_issued ? bus.in_mem_rd_word : r_ext_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                                 |
// | Brief    : Directed scenarios plus randomized traffic against a rule model |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int AW    = 12;
  localparam int WW    = 16;
  localparam int LIMIT = 4;
  localparam int CW    = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  dmem_arbiter_if #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW)) bus ();

  dmem_arbiter #(
    .DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous single-port memory: read data appears the cycle after the access.
  logic [WW-1:0] ram [0:4095];
  logic [WW-1:0] ram_rd_word = '0;
  int            mem_writes  = 0;
  assign bus.in_mem_rd_word = ram_rd_word;
  always @(posedge clock) begin
    if (bus.out_mem_en) begin
      if (bus.out_mem_we) begin
        ram[bus.out_mem_addr] <= bus.out_mem_wr_word;
        mem_writes            <= mem_writes + 1;
      end else begin
        ram_rd_word <= ram[bus.out_mem_addr];
      end
    end
  end

  task automatic idle();
    bus.in_cpu_rd_en = 1'b0; bus.in_cpu_rd_addr = '0;
    bus.in_cpu_wr_en = 1'b0; bus.in_cpu_wr_addr = '0; bus.in_cpu_wr_word = '0;
    bus.in_ext_req   = 1'b0; bus.in_ext_we = 1'b0; bus.in_ext_addr = '0; bus.in_ext_wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  task automatic ext_drive(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] data);
    bus.in_ext_req = 1'b1; bus.in_ext_we = we; bus.in_ext_addr = addr; bus.in_ext_wdata = data;
  endtask

  task automatic test_reset();
    bus.in_cpu_rd_en = 1'b1; bus.in_cpu_rd_addr = 12'h123;
    bus.in_cpu_wr_en = 1'b1; bus.in_cpu_wr_addr = 12'h321; bus.in_cpu_wr_word = 16'hAAAA;
    ext_drive(1'b1, 12'h111, 16'h5555);
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_en, bus.out_mem_we, bus.out_ext_rvalid} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_en, bus.out_mem_we, bus.out_ext_rvalid}); end
    checks++; if (bus.out_mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 000", bus.out_mem_addr); end
    checks++; if (bus.out_mem_wr_word !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0000", bus.out_mem_wr_word); end
    checks++; if (bus.out_ext_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.out_ext_rdata); end
    cyc(); idle(); reset = 1'b0;
    samp();
    checks++; if ({bus.out_mem_en, bus.out_cpu_stall, bus.out_ext_gnt} !== 3'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 000", {bus.out_mem_en, bus.out_cpu_stall, bus.out_ext_gnt}); end
  endtask

  task automatic test_ext_read();
    cyc(); ext_drive(1'b1, 12'h010, 16'hBEEF);
    samp();
    checks++; if (bus.out_ext_gnt !== 1'b1) begin errors++; $display("FAIL ext_preload_gnt: got %b want 1", bus.out_ext_gnt); end
    cyc(); ext_drive(1'b0, 12'h010, 16'h0000);
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_mem_en, bus.out_mem_we, bus.out_cpu_stall} !== 4'b1100) begin errors++; $display("FAIL ext_read_ctrl: got %b want 1100", {bus.out_ext_gnt, bus.out_mem_en, bus.out_mem_we, bus.out_cpu_stall}); end
    checks++; if (bus.out_mem_addr !== 12'h010) begin errors++; $display("FAIL ext_read_addr: got %h want 010", bus.out_mem_addr); end
    cyc(); idle();
    samp();
    checks++; if ({bus.out_ext_rvalid, bus.out_cpu_stall} !== 2'b10) begin errors++; $display("FAIL ext_read_rvalid: got %b want 10", {bus.out_ext_rvalid, bus.out_cpu_stall}); end
    checks++; if (bus.out_ext_rdata !== 16'hBEEF) begin errors++; $display("FAIL ext_read_rdata: got %h want beef", bus.out_ext_rdata); end
    cyc();
    samp();
    checks++; if (bus.out_ext_rvalid !== 1'b0) begin errors++; $display("FAIL ext_read_rvalid_pulse: got %b want 0", bus.out_ext_rvalid); end
    checks++; if (bus.out_ext_rdata !== 16'hBEEF) begin errors++; $display("FAIL ext_read_rdata_hold: got %h want beef", bus.out_ext_rdata); end
  endtask

  task automatic test_ext_write_read();
    cyc(); ext_drive(1'b1, 12'h040, 16'h5A5A);
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_mem_en, bus.out_mem_we} !== 3'b111) begin errors++; $display("FAIL ext_wr_ctrl: got %b want 111", {bus.out_ext_gnt, bus.out_mem_en, bus.out_mem_we}); end
    checks++; if ({bus.out_mem_addr, bus.out_mem_wr_word} !== {12'h040, 16'h5A5A}) begin errors++; $display("FAIL ext_wr_bus: got %h/%h want 040/5a5a", bus.out_mem_addr, bus.out_mem_wr_word); end
    cyc(); ext_drive(1'b0, 12'h040, 16'h0000);
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_mem_we, bus.out_ext_rvalid} !== 3'b100) begin errors++; $display("FAIL ext_rd_ctrl: got %b want 100", {bus.out_ext_gnt, bus.out_mem_we, bus.out_ext_rvalid}); end
    cyc(); idle();
    samp();
    checks++; if ({bus.out_ext_rvalid, bus.out_ext_rdata} !== {1'b1, 16'h5A5A}) begin errors++; $display("FAIL ext_wr_rd_data: got %b/%h want 1/5a5a", bus.out_ext_rvalid, bus.out_ext_rdata); end
    cyc();
    samp();
    checks++; if (bus.out_ext_rvalid !== 1'b0) begin errors++; $display("FAIL ext_wr_rd_pulse: got %b want 0", bus.out_ext_rvalid); end
  endtask

  task automatic test_starvation();
    logic [AW-1:0] a;
    for (int i = 0; i < LIMIT; i++) begin
      cyc(); a = AW'($urandom); bus.in_cpu_rd_en = 1'b1; bus.in_cpu_rd_addr = a;
      ext_drive(1'b0, 12'h055, 16'h0000);
      samp();
      checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_addr} !== {2'b00, a}) begin errors++; $display("FAIL starve_deny_%0d: got %b%b/%h want 00/%h", i, bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_addr, a); end
    end
    cyc(); bus.in_cpu_rd_addr = AW'($urandom);
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_we, bus.out_mem_addr} !== {3'b110, 12'h055}) begin errors++; $display("FAIL starve_force: got %b%b%b/%h want 110/055", bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_we, bus.out_mem_addr); end
    // A fresh request right away must wait the full bound again.
    cyc(); a = AW'($urandom); bus.in_cpu_rd_addr = a; ext_drive(1'b0, 12'h056, 16'h0000);
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall, bus.out_ext_rvalid, bus.out_mem_addr} !== {3'b001, a}) begin errors++; $display("FAIL starve_cpu_after: got %b%b%b/%h want 001/%h", bus.out_ext_gnt, bus.out_cpu_stall, bus.out_ext_rvalid, bus.out_mem_addr, a); end
    for (int i = 1; i < LIMIT; i++) begin
      cyc(); bus.in_cpu_rd_addr = AW'($urandom);
      samp();
      checks++; if (bus.out_ext_gnt !== 1'b0) begin errors++; $display("FAIL starve_redeny_%0d: got %b want 0", i, bus.out_ext_gnt); end
    end
    cyc();
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_mem_addr} !== {1'b1, 12'h056}) begin errors++; $display("FAIL starve_reforce: got %b/%h want 1/056", bus.out_ext_gnt, bus.out_mem_addr); end
    cyc(); idle();
  endtask

  task automatic test_wr_rd_same();
    int w0;
    w0 = mem_writes;
    cyc();
    bus.in_cpu_wr_en = 1'b1; bus.in_cpu_wr_addr = 12'h020; bus.in_cpu_wr_word = 16'h1234;
    bus.in_cpu_rd_en = 1'b1; bus.in_cpu_rd_addr = 12'h030;
    samp();
    checks++; if ({bus.out_mem_en, bus.out_mem_we, bus.out_cpu_stall, bus.out_mem_addr, bus.out_mem_wr_word} !== {3'b111, 12'h020, 16'h1234}) begin errors++; $display("FAIL wrrd_write: got %b%b%b/%h/%h want 111/020/1234", bus.out_mem_en, bus.out_mem_we, bus.out_cpu_stall, bus.out_mem_addr, bus.out_mem_wr_word); end
    cyc();
    samp();
    checks++; if ({bus.out_mem_en, bus.out_mem_we, bus.out_cpu_stall, bus.out_mem_addr} !== {3'b100, 12'h030}) begin errors++; $display("FAIL wrrd_read: got %b%b%b/%h want 100/030", bus.out_mem_en, bus.out_mem_we, bus.out_cpu_stall, bus.out_mem_addr); end
    cyc(); idle();
    samp();
    checks++; if (mem_writes - w0 !== 1) begin errors++; $display("FAIL wrrd_write_count: got %0d want 1", mem_writes - w0); end
    checks++; if (ram[12'h020] !== 16'h1234) begin errors++; $display("FAIL wrrd_mem_word: got %h want 1234", ram[12'h020]); end
  endtask

  task automatic test_store_vs_ext();
    cyc();
    bus.in_cpu_wr_en = 1'b1; bus.in_cpu_wr_addr = 12'h0AA; bus.in_cpu_wr_word = 16'hC0DE;
    ext_drive(1'b0, 12'h0BB, 16'h0000);
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_we, bus.out_mem_addr} !== {3'b001, 12'h0AA}) begin errors++; $display("FAIL store_vs_ext: got %b%b%b/%h want 001/0aa", bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_we, bus.out_mem_addr); end
    for (int i = 1; i < LIMIT; i++) begin
      cyc(); bus.in_cpu_wr_word = WW'($urandom);
      samp();
      checks++; if (bus.out_ext_gnt !== 1'b0) begin errors++; $display("FAIL store_deny_%0d: got %b want 0", i, bus.out_ext_gnt); end
    end
    cyc();
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_addr} !== {2'b11, 12'h0BB}) begin errors++; $display("FAIL store_force: got %b%b/%h want 11/0bb", bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_addr); end
    cyc(); idle();
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] d;
    logic          exp_rv;
    logic [WW-1:0] exp_rd;
    exp_rv = 1'b0; exp_rd = '0; d = '0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i % 2 == 0) begin d = WW'($urandom); ext_drive(1'b1, AW'(12'h060 + i / 2), d); end
      else ext_drive(1'b0, AW'(12'h060 + i / 2), 16'h0000);
      samp();
      checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall} !== 2'b10) begin errors++; $display("FAIL b2b_gnt_%0d: got %b%b want 10", i, bus.out_ext_gnt, bus.out_cpu_stall); end
      checks++; if (bus.out_ext_rvalid !== exp_rv || (exp_rv && bus.out_ext_rdata !== exp_rd)) begin errors++; $display("FAIL b2b_ret_%0d: got %b/%h want %b/%h", i, bus.out_ext_rvalid, bus.out_ext_rdata, exp_rv, exp_rd); end
      exp_rv = (i % 2 == 1); exp_rd = d;
    end
    cyc(); idle();
    samp();
    checks++; if ({bus.out_ext_rvalid, bus.out_ext_rdata} !== {1'b1, d}) begin errors++; $display("FAIL b2b_last_ret: got %b/%h want 1/%h", bus.out_ext_rvalid, bus.out_ext_rdata, d); end
  endtask

  task automatic test_reset_mid();
    cyc(); ext_drive(1'b0, 12'h010, 16'h0000);
    samp();
    checks++; if (bus.out_ext_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b want 1", bus.out_ext_gnt); end
    cyc(); idle(); reset = 1'b1; #1;
    checks++; if ({bus.out_ext_rvalid, bus.out_ext_rdata} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL rstmid_drop_ret: got %b/%h want 0/0000", bus.out_ext_rvalid, bus.out_ext_rdata); end
    cyc(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.in_cpu_rd_en = 1'b1; bus.in_cpu_rd_addr = AW'($urandom); ext_drive(1'b0, 12'h077, 16'h0000);
      samp();
      checks++; if ({bus.out_ext_gnt, bus.out_ext_rvalid} !== 2'b00) begin errors++; $display("FAIL rstmid_wait_%0d: got %b%b want 00", i, bus.out_ext_gnt, bus.out_ext_rvalid); end
    end
    cyc(); reset = 1'b1; #1;
    checks++; if ({bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_en, bus.out_mem_we, bus.out_ext_rvalid, bus.out_mem_addr} !== {5'b0, 12'h000}) begin errors++; $display("FAIL rstmid_outputs: got %b%b%b%b%b/%h want 00000/000", bus.out_ext_gnt, bus.out_cpu_stall, bus.out_mem_en, bus.out_mem_we, bus.out_ext_rvalid, bus.out_mem_addr); end
    cyc(); reset = 1'b0;
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_ext_rvalid} !== 2'b00) begin errors++; $display("FAIL rstmid_restart: got %b%b want 00", bus.out_ext_gnt, bus.out_ext_rvalid); end
    for (int i = 1; i < LIMIT; i++) begin
      cyc(); bus.in_cpu_rd_addr = AW'($urandom);
      samp();
      checks++; if (bus.out_ext_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_deny_%0d: got %b want 0", i, bus.out_ext_gnt); end
    end
    cyc();
    samp();
    checks++; if ({bus.out_ext_gnt, bus.out_mem_addr} !== {1'b1, 12'h077}) begin errors++; $display("FAIL rstmid_force: got %b/%h want 1/077", bus.out_ext_gnt, bus.out_mem_addr); end
    cyc(); idle();
  endtask

  // Randomized traffic; expectations come from the priority rules applied to a
  // small abstract state (waited cycles, deferred read, outstanding return).
  task automatic test_random();
    int            m_wait;
    bit            m_pend, m_ret, prev_stall, prev_gnt;
    logic [WW-1:0] m_hold, m_ret_data;
    logic [WW-1:0] refm [16];
    bit            e_gnt, e_stall, e_en, e_we, served_cpu_wr, served_cpu_rd;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wdata, e_rdata;
    int            rerr;
    cyc(); idle(); reset = 1'b1;
    cyc(); reset = 1'b0;
    m_wait = 0; m_pend = 0; m_ret = 0; prev_stall = 0; prev_gnt = 0; m_hold = '0; m_ret_data = '0; rerr = 0;
    for (int n = 0; n < 600 && rerr < 10; n++) begin
      cyc();
      if (!prev_stall) begin
        if (n < 16) begin
          bus.in_cpu_rd_en = 1'b0; bus.in_cpu_wr_en = 1'b1;
          bus.in_cpu_wr_addr = AW'(12'h100 + n); bus.in_cpu_wr_word = WW'($urandom);
        end else begin
          bus.in_cpu_rd_en = 1'($urandom_range(0, 1));
          bus.in_cpu_wr_en = ($urandom_range(0, 2) == 0);
          bus.in_cpu_rd_addr = AW'(12'h100 + $urandom_range(0, 15));
          bus.in_cpu_wr_addr = AW'(12'h100 + $urandom_range(0, 15));
          bus.in_cpu_wr_word = WW'($urandom);
        end
      end
      if (!(bus.in_ext_req && !prev_gnt)) begin
        bus.in_ext_req   = (n >= 16) && ($urandom_range(0, 1) == 1);
        bus.in_ext_we    = 1'($urandom_range(0, 1));
        bus.in_ext_addr  = AW'(12'h100 + $urandom_range(0, 15));
        bus.in_ext_wdata = WW'($urandom);
      end
      e_gnt = 0; e_stall = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      served_cpu_wr = 0; served_cpu_rd = 0;
      if (m_wait == LIMIT && bus.in_ext_req) begin
        e_gnt = 1; e_stall = (bus.in_cpu_wr_en && !m_pend) || bus.in_cpu_rd_en;
      end else if (bus.in_cpu_wr_en && !m_pend) begin
        served_cpu_wr = 1; e_stall = bus.in_cpu_rd_en;
        e_en = 1; e_we = 1; e_addr = bus.in_cpu_wr_addr; e_wdata = bus.in_cpu_wr_word;
      end else if (bus.in_cpu_rd_en) begin
        served_cpu_rd = 1; e_en = 1; e_addr = bus.in_cpu_rd_addr;
      end else if (bus.in_ext_req) begin
        e_gnt = 1;
      end
      if (e_gnt) begin
        e_en = 1; e_we = bus.in_ext_we; e_addr = bus.in_ext_addr;
        e_wdata = bus.in_ext_we ? bus.in_ext_wdata : '0;
      end
      e_rdata = m_ret ? m_ret_data : m_hold;
      samp();
      checks++; if (bus.out_ext_gnt !== e_gnt) begin errors++; rerr++; $display("FAIL rand_gnt@%0d: got %b want %b", n, bus.out_ext_gnt, e_gnt); end
      checks++; if (bus.out_cpu_stall !== e_stall) begin errors++; rerr++; $display("FAIL rand_stall@%0d: got %b want %b", n, bus.out_cpu_stall, e_stall); end
      checks++; if ({bus.out_mem_en, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wr_word} !== {e_en, e_we, e_addr, e_wdata}) begin errors++; rerr++; $display("FAIL rand_mem@%0d: got %b%b/%h/%h want %b%b/%h/%h", n, bus.out_mem_en, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wr_word, e_en, e_we, e_addr, e_wdata); end
      checks++; if (bus.out_ext_rvalid !== m_ret) begin errors++; rerr++; $display("FAIL rand_rvalid@%0d: got %b want %b", n, bus.out_ext_rvalid, m_ret); end
      checks++; if (bus.out_ext_rdata !== e_rdata) begin errors++; rerr++; $display("FAIL rand_rdata@%0d: got %h want %h", n, bus.out_ext_rdata, e_rdata); end
      if (m_ret) m_hold = m_ret_data;
      m_ret = e_gnt && !bus.in_ext_we;
      if (m_ret) m_ret_data = refm[e_addr[3:0]];
      if (e_en && e_we) refm[e_addr[3:0]] = e_wdata;
      if (!bus.in_ext_req || e_gnt) m_wait = 0;
      else if (m_wait < LIMIT) m_wait = m_wait + 1;
      if (served_cpu_wr) m_pend = bus.in_cpu_rd_en;
      else if (served_cpu_rd) m_pend = 0;
      prev_stall = e_stall; prev_gnt = e_gnt;
    end
    cyc(); idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_ext_read();
    test_ext_write_read();
    test_starvation();
    test_wr_rd_same();
    test_store_vs_ext();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
